// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stage enable/flush sequencer for the five-stage core
//   (load-use, Mem-stage redirect, multi-cycle data memory with watchdog).
//   Optional performance counters: define PIPE_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        mem_redirect,
  input  logic        mem_access,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        pc_sel_jump,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_C = MEM_TIMEOUT[7:0];

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       load_use;
  logic       mem_hold;
  logic       mem_abort;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // In RUN a new unacknowledged access starts the wait; in MEM_WAIT the
  // hold continues until ready or the watchdog limit is reached.
  assign mem_hold  = (state_q == RUN) ? (mem_access && !dmem_ready)
                                      : (!dmem_ready && (wait_cnt_q < TIMEOUT_C));
  assign mem_abort = (state_q == MEM_WAIT) && !dmem_ready &&
                     (wait_cnt_q >= TIMEOUT_C);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = RUN;
    wait_cnt_d   = 8'd0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    pc_sel_jump  = 1'b0;
    mem_err      = 1'b0;

    if (!rstn) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_hold) begin
      // Freeze everything up to EX/Mem; Mem/WB keeps loading bubbles.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      state_d      = MEM_WAIT;
      wait_cnt_d   = (state_q == RUN) ? 8'd1 : wait_cnt_q + 8'd1;
    end else if (mem_abort) begin
      mem_err      = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_redirect) begin
      pc_sel_jump  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (!pc_en && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (pc_sel_jump && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle expected control
// vectors are queued at drive time and compared when sampled.
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read;
  logic        mem_redirect, mem_access, dmem_ready;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic        pc_sel_jump, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_redirect(mem_redirect), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .pc_sel_jump(pc_sel_jump), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {pc,ifid,idex,exmem,memwb enables | ifid,idex,exmem,memwb flushes | jump, err}
  localparam logic [10:0] V_RST = 11'b00000_1111_0_0;
  localparam logic [10:0] V_RUN = 11'b11111_0000_0_0;
  localparam logic [10:0] V_LU  = 11'b00111_0100_0_0;
  localparam logic [10:0] V_WT  = 11'b00001_0001_0_0;
  localparam logic [10:0] V_RDR = 11'b11111_1110_1_0;
  localparam logic [10:0] V_ABT = 11'b11111_0001_0_1;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_stall = 32'd0;
  logic [31:0] exp_flush = 32'd0;
  bit          primed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] obs_vec();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
            pc_sel_jump, mem_err};
  endfunction

  // One pipeline cycle: queue expectation, sample mid-cycle, advance.
  task automatic step(input string tag, input logic [10:0] exp);
    sb_t e;
    sb_q.push_back('{tag, exp});
    @(negedge clk);
    e = sb_q.pop_front();
    chk(e.tag, {21'd0, obs_vec()}, {21'd0, e.exp});
    if (primed) begin
      chk({e.tag, ".stall_cnt"}, stall_cnt, exp_stall);
      chk({e.tag, ".flush_cnt"}, flush_cnt, exp_flush);
    end
`ifdef PIPE_PERF_CNT_EN
    if (!rstn) begin
      exp_stall = 32'd0;
      exp_flush = 32'd0;
    end else begin
      if (!e.exp[10]) exp_stall = exp_stall + 32'd1;
      if (e.exp[1])   exp_flush = exp_flush + 32'd1;
    end
`endif
    if (!rstn) primed = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    mem_redirect = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;

    step("reset0", V_RST);
    step("reset1", V_RST);
    rstn = 1'b1;
    step("run_idle", V_RUN);

    // lw x5 in EX, add x6,x5,x1 in ID
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_rs2 = 5'd1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    step("lu_rs1", V_LU);
    id_rs1 = 5'd3; id_rs2 = 5'd5;
    step("lu_rs2", V_LU);
    id_use_rs2 = 1'b0;
    step("lu_rs2_unused", V_RUN);
    ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    step("lu_x0", V_RUN);
    ex_rd = 5'd5; id_rs1 = 5'd5; ex_mem_read = 1'b0;
    step("lu_noload", V_RUN);

    // redirect alone, then redirect with a load-use pending
    mem_redirect = 1'b1;
    step("redirect", V_RDR);
    ex_mem_read = 1'b1;
    step("redirect_lu", V_RDR);
    mem_redirect = 1'b0; ex_mem_read = 1'b0;
    step("post_redirect", V_RUN);

    // 3-cycle memory wait
    mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("mwait3", V_WT);
    dmem_ready = 1'b1;
    step("mwait3_ready", V_RUN);
    mem_access = 1'b0;
    step("mwait3_after", V_RUN);

    // redirect held during a wait is acted on in the ready cycle
    mem_access = 1'b1; dmem_ready = 1'b0; mem_redirect = 1'b1;
    step("wait_rdr0", V_WT);
    step("wait_rdr1", V_WT);
    dmem_ready = 1'b1;
    step("wait_rdr_ready", V_RDR);
    mem_access = 1'b0; mem_redirect = 1'b0;
    step("wait_rdr_after", V_RUN);

    // load-use resolved in the ready cycle
    mem_access = 1'b1; dmem_ready = 1'b0;
    step("wait_lu0", V_WT);
    dmem_ready = 1'b1; ex_mem_read = 1'b1;
    step("wait_lu_ready", V_LU);
    ex_mem_read = 1'b0; mem_access = 1'b0;
    step("wait_lu_after", V_RUN);

    // watchdog abort after MEM_TIMEOUT=4 stall cycles
    mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("tmo_wait", V_WT);
    step("tmo_abort", V_ABT);
    mem_access = 1'b0;
    step("tmo_after0", V_RUN);
    step("tmo_after1", V_RUN);

    // reset in the second MEM_WAIT cycle
    mem_access = 1'b1;
    step("rstw_enter", V_WT);
    step("rstw_wait1", V_WT);
    rstn = 1'b0;
    step("rstw_reset", V_RST);
    rstn = 1'b1;
    // wait counter must restart from zero: full 4 stalls before abort again
    for (int i = 0; i < 4; i++) step("rstw_tmo_wait", V_WT);
    step("rstw_tmo_abort", V_ABT);
    mem_access = 1'b0;
    step("rstw_run", V_RUN);

    mem_redirect = 1'b1;
    step("final_redirect", V_RDR);
    mem_redirect = 1'b0;
    step("final_run", V_RUN);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the five-stage RISC-V Lite core. It drives the enable and synchronous-flush inputs of the PC and the IF/ID, ID/EX, EX/Mem and Mem/WB registers. It resolves three conditions: load-use hazards, taken branches and jumps resolved in the Mem stage, and multi-cycle data-memory accesses. A watchdog aborts any memory access that is never acknowledged.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum number of wait cycles per data-memory access before abort. Legal range 2..255.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rstn  in  1  reset; one clock, reset is synchronous and active-low.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads rs1 / rs2.
- ex_mem_read  in  1  the ID/EX-stage instruction is a load (M_ctrl.MemRead).
- ex_rd  in  5  destination register of the ID/EX-stage instruction.
- mem_redirect  in  1  the EX/Mem output requests a redirect: (branch & bit_branch) | jump.
- mem_access  in  1  the EX/Mem instruction accesses data memory (CS active).
- dmem_ready  in  1  data memory completes the current access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  the register loads a bubble (its reset values) on the next edge.
- pc_sel_jump  out  1  PC mux selects the EX/Mem PC_jump.
- mem_err  out  1  one-cycle pulse on a memory timeout abort.
- stall_cnt, flush_cnt  out  32 each  performance counters (see Configuration).

## Operation
- FSM states are RUN and MEM_WAIT. Outputs are Mealy: a function of the registered state and the current inputs, valid in the same cycle.
- Reset (rstn=0):
  - all *_en = 0; all *_flush = 1.
  - pc_sel_jump = 0, mem_err = 0.
  - state = RUN, wait_cnt = 0, stall_cnt = 0, flush_cnt = 0.
- RUN default: all *_en = 1; all *_flush = 0; pc_sel_jump = 0.
- Conditions are evaluated in priority order: memory wait, then redirect, then load-use.
- Memory wait, RUN with mem_access=1 and dmem_ready=0:
  - all *_en = 0, except mem_wb_en = 1 with mem_wb_flush = 1, so Mem/WB takes a bubble.
  - next state = MEM_WAIT; wait_cnt = 1.
- MEM_WAIT with dmem_ready=0 and wait_cnt < MEM_TIMEOUT: same outputs as memory wait; wait_cnt increments.
- MEM_WAIT with dmem_ready=1:
  - outputs are those of RUN with the stalled condition removed, then the redirect and load-use rules are applied.
  - next state = RUN; wait_cnt = 0.
- MEM_WAIT with dmem_ready=0 and wait_cnt = MEM_TIMEOUT (abort):
  - mem_err = 1; all *_en = 1; mem_wb_flush = 1, so the aborted load never writes back.
  - next state = RUN; wait_cnt = 0.
- Redirect (mem_redirect=1, no memory wait this cycle):
  - pc_sel_jump = 1.
  - if_id_flush, id_ex_flush and ex_mem_flush = 1; all enables = 1.
  - The redirecting instruction itself advances into Mem/WB.
- Load-use, applied only when there is no redirect and no memory wait:
  - condition: ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
  - response: pc_en = 0, if_id_en = 0, id_ex_flush = 1; other stages advance.
- Simultaneous events:
  - redirect + load-use: redirect wins; the hazard instruction is flushed anyway.
  - memory wait + redirect: redirect is deferred until the access completes. mem_redirect is still asserted from the frozen EX/Mem register and is acted on in the ready cycle.
- Reset mid-MEM_WAIT: state returns to RUN immediately; no mem_err pulse.

## Timing
- Hazard and redirect responses take effect on the edge ending the cycle in which they are detected (zero added latency).
- Load-use costs exactly 1 bubble. A taken redirect costs 3 flushed slots.
- A memory access acknowledged after N wait cycles (dmem_ready low for N cycles) stalls the pipeline for exactly N cycles.
- Abort occurs on cycle MEM_TIMEOUT+1 after entering the wait, i.e. after MEM_TIMEOUT stall cycles.
- mem_err is high for exactly one cycle per abort.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_cnt increments once per cycle in which pc_en = 0 and rstn = 1.
  - flush_cnt increments once per redirect cycle.
  - Both counters saturate at 32'hFFFF_FFFF and clear only on reset.
- PIPE_PERF_CNT_EN undefined: both ports are driven constant 0 and no counter flops are synthesized.

## Test plan
- Load-use: `lw x5` in EX with `add x6,x5,x1` in ID → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1. Also check ex_rd=0 → no stall.
- Taken branch, mem_redirect=1 for one cycle → pc_sel_jump=1 and three flushes in that cycle; flush_cnt goes 0→1 with PIPE_PERF_CNT_EN defined.
- Memory wait, mem_access=1 with dmem_ready low for 3 cycles → exactly 3 frozen cycles with mem_wb_flush=1, then RUN; stall_cnt=3.
- Timeout with MEM_TIMEOUT=4 and dmem_ready held 0 → 4 stall cycles, then a 1-cycle mem_err pulse and RUN, with no further error pulses.
- Redirect during a memory wait → no pc_sel_jump while stalled; pc_sel_jump=1 in the dmem_ready cycle.
- rstn dropped in the second MEM_WAIT cycle → next cycle all enables 0, all flushes 1, mem_err 0; after release, RUN with all enables 1.
